vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator for the VGA video path. It produces horizontal and vertical sync, a display-enable, pixel coordinates and line/frame start strobes from independently configurable porch and sync lengths. Each axis is sequenced by a four-phase state machine. A pixel clock-enable lets one system clock drive any pixel rate. It replaces the fixed-geometry sync generator and feeds the pixel-pattern and framebuffer read logic directly.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BP, 33: vertical back porch, lines
- H_SYNC_POL, 0: 0 = h_sync active-low, 1 = active-high
- V_SYNC_POL, 0: 0 = v_sync active-low, 1 = active-high
- X_W, 11: width of x; must hold H_TOTAL-1
- Y_W, 10: width of y; must hold V_TOTAL-1

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel enable; raster advances one pixel per clk with ce=1
- h_sync  out  1  horizontal sync, polarity per H_SYNC_POL
- v_sync  out  1  vertical sync, polarity per V_SYNC_POL
- active  out  1  current pixel is in the visible area
- x  out  X_W  current pixel column, 0..H_TOTAL-1
- y  out  Y_W  current line, 0..V_TOTAL-1
- line_start  out  1  one-clk strobe when x becomes 0
- frame_start  out  1  one-clk strobe when (x,y) becomes (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Every length parameter ≥ 1; violation is an elaboration error. Widths too narrow for H_TOTAL-1 / V_TOTAL-1 are also an elaboration error.
- Horizontal FSM states: H_ACT, H_FP, H_SYN, H_BP. A per-phase counter counts pixels in the phase; the last pixel of a phase moves to the next phase, with H_BP wrapping to H_ACT.
- Vertical FSM states: V_ACT, V_FP, V_SYN, V_BP. It advances only on the ce cycle that wraps H_BP to H_ACT (end of line), so vertical phases change when x becomes 0.
- x increments on each ce and wraps H_TOTAL-1 to 0. y increments on x wrap and wraps V_TOTAL-1 to 0.
- active = (H state = H_ACT) and (V state = V_ACT), equivalently x < H_ACTIVE and y < V_ACTIVE.
- h_sync is asserted for H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC. v_sync is asserted for whole lines V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC.
- All outputs are registered and mutually aligned: x, y, active, h_sync, v_sync, line_start and frame_start always describe the same pixel.
- ce=0: all state and outputs hold, except line_start and frame_start, which are forced to 0.

## Timing
- Reset (rst=1 at a clk edge): x=0, y=0, active=0, h_sync and v_sync at their inactive level (1 for pol 0, 0 for pol 1), line_start=0, frame_start=0. FSMs are held in a pre-start state.
- First ce cycle after rst deasserts: outputs present pixel (0,0) with active=1, line_start=1 and frame_start=1, all in the same clk.
- Latency: an output change appears the clk after the ce edge that causes it; there is no further pipeline.
- Strobes are exactly one clk wide, even when ce stays high.
- rst asserted mid-line or mid-frame takes precedence over ce. Outputs go to reset values on that edge, and the raster restarts at (0,0) on the first ce after release.
- End-of-frame corner, pixel (H_TOTAL-1, V_TOTAL-1) followed by ce: x=0, y=0, line_start=1, frame_start=1, v_sync inactive unless V_SYNC covers line 0 (impossible with V_ACTIVE ≥ 1).

## Test plan
- Default params, ce=1 always, reset, then run 2 frames: a frame_start every 420000 clks (800×525); a line_start every 800 clks; active high for exactly 307200 clks per frame; h_sync low for x=656..751; v_sync low for y=490..491.
- Tiny params H 4/1/2/1, V 3/1/1/1, pols 1/1: check the x sequence 0..7 and y 0..5; h_sync=1 only at x=5,6; v_sync=1 only at y=4; active only for x<4 and y<3; frame_start period 48 clks.
- Same tiny params, ce toggling 1,0,1,0: raster period doubles to 96 clks; strobes remain 1 clk wide and never occur on ce=0 cycles; x and y hold during ce=0.
- Assert rst for 1 clk at default params while x=300, y=200: next clk shows reset values; the first ce afterwards gives (0,0) with both strobes set.
- Boundary wrap at tiny params: step to (7,5), then one ce: x=0, y=0, frame_start=1, active=1.
- Polarity flip (H_SYNC_POL=0, V_SYNC_POL=1): during reset h_sync=1 and v_sync=0; the sync windows match the first test's windows with v_sync inverted.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator: sync, display enable, pixel coordinates, line/frame strobes
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int X_W        = 11,
    parameter int Y_W        = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    output logic           h_sync,
    output logic           v_sync,
    output logic           active,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic H_ON = (H_SYNC_POL != 0);
    localparam logic V_ON = (V_SYNC_POL != 0);

    // Shared phase encoding for both axes; ST_IDLE is the pre-start state held from reset until the first ce.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ACT  = 3'd1;
    localparam logic [2:0] ST_FP   = 3'd2;
    localparam logic [2:0] ST_SYN  = 3'd3;
    localparam logic [2:0] ST_BP   = 3'd4;

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_length
            $error("vga_timing_gen: every porch, sync and active length must be at least 1");
        end
        if (X_W < 1 || X_W > 30 || (H_TOTAL - 1) >= (1 << X_W)) begin : g_bad_x_w
            $error("vga_timing_gen: X_W too narrow for H_TOTAL-1");
        end
        if (Y_W < 1 || Y_W > 30 || (V_TOTAL - 1) >= (1 << Y_W)) begin : g_bad_y_w
            $error("vga_timing_gen: Y_W too narrow for V_TOTAL-1");
        end
    endgenerate

    function automatic logic [X_W-1:0] h_last(input logic [2:0] st);
        case (st)
            ST_ACT:  h_last = X_W'(H_ACTIVE - 1);
            ST_FP:   h_last = X_W'(H_FP - 1);
            ST_SYN:  h_last = X_W'(H_SYNC - 1);
            ST_BP:   h_last = X_W'(H_BP - 1);
            default: h_last = '0;
        endcase
    endfunction

    function automatic logic [Y_W-1:0] v_last(input logic [2:0] st);
        case (st)
            ST_ACT:  v_last = Y_W'(V_ACTIVE - 1);
            ST_FP:   v_last = Y_W'(V_FP - 1);
            ST_SYN:  v_last = Y_W'(V_SYNC - 1);
            ST_BP:   v_last = Y_W'(V_BP - 1);
            default: v_last = '0;
        endcase
    endfunction

    function automatic logic [2:0] next_phase(input logic [2:0] st);
        case (st)
            ST_ACT:  next_phase = ST_FP;
            ST_FP:   next_phase = ST_SYN;
            ST_SYN:  next_phase = ST_BP;
            default: next_phase = ST_ACT;
        endcase
    endfunction

    logic [2:0]     r_h_state;
    logic [2:0]     r_v_state;
    logic [X_W-1:0] r_h_cnt;
    logic [Y_W-1:0] r_v_cnt;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           r_active;
    logic           r_h_sync;
    logic           r_v_sync;
    logic           r_line_start;
    logic           r_frame_start;

    logic           w_start;
    logic           w_h_last;
    logic           w_v_last;
    logic           w_eol;
    logic           w_eof;
    logic [2:0]     w_h_state_nxt;
    logic [2:0]     w_v_state_nxt;
    logic [X_W-1:0] w_h_cnt_nxt;
    logic [Y_W-1:0] w_v_cnt_nxt;
    logic [X_W-1:0] w_x_nxt;
    logic [Y_W-1:0] w_y_nxt;

    assign w_start  = (r_h_state == ST_IDLE);
    assign w_h_last = (r_h_cnt == h_last(r_h_state));
    assign w_v_last = (r_v_cnt == v_last(r_v_state));
    assign w_eol    = (r_h_state == ST_BP) && w_h_last;
    assign w_eof    = w_eol && (r_v_state == ST_BP) && w_v_last;

    // Next pixel; the vertical axis only moves on the end-of-line step.
    always_comb begin
        w_h_state_nxt = r_h_state;
        w_v_state_nxt = r_v_state;
        w_h_cnt_nxt   = r_h_cnt;
        w_v_cnt_nxt   = r_v_cnt;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        if (w_start) begin
            w_h_state_nxt = ST_ACT;
            w_v_state_nxt = ST_ACT;
            w_h_cnt_nxt   = '0;
            w_v_cnt_nxt   = '0;
            w_x_nxt       = '0;
            w_y_nxt       = '0;
        end else begin
            w_x_nxt = w_eol ? '0 : r_x + X_W'(1);
            if (w_h_last) begin
                w_h_state_nxt = next_phase(r_h_state);
                w_h_cnt_nxt   = '0;
            end else begin
                w_h_cnt_nxt   = r_h_cnt + X_W'(1);
            end
            if (w_eol) begin
                w_y_nxt = w_eof ? '0 : r_y + Y_W'(1);
                if (w_v_last) begin
                    w_v_state_nxt = next_phase(r_v_state);
                    w_v_cnt_nxt   = '0;
                end else begin
                    w_v_cnt_nxt   = r_v_cnt + Y_W'(1);
                end
            end
        end
    end

    // Outputs are registered from the next-state values so they describe the same pixel as the FSMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_state     <= ST_IDLE;
            r_v_state     <= ST_IDLE;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_active      <= 1'b0;
            r_h_sync      <= ~H_ON;
            r_v_sync      <= ~V_ON;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (ce) begin
            r_h_state     <= w_h_state_nxt;
            r_v_state     <= w_v_state_nxt;
            r_h_cnt       <= w_h_cnt_nxt;
            r_v_cnt       <= w_v_cnt_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_active      <= (w_h_state_nxt == ST_ACT) && (w_v_state_nxt == ST_ACT);
            r_h_sync      <= (w_h_state_nxt == ST_SYN) ? H_ON : ~H_ON;
            r_v_sync      <= (w_v_state_nxt == ST_SYN) ? V_ON : ~V_ON;
            r_line_start  <= w_start || w_eol;
            r_frame_start <= w_start || w_eof;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign h_sync      = r_h_sync;
    assign v_sync      = r_v_sync;
    assign active      = r_active;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized raster check of three geometries against a linear-position model
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  ce;
    logic [2:0]  rst;
    logic [2:0]  o_hs, o_vs, o_act, o_ls, o_fs;
    logic [10:0] o_x [3];
    logic [9:0]  o_y [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Geometry per instance: 0 default, 1 tiny, 2 default-H / short-V with flipped v_sync polarity.
    int g_ha[3], g_hfp[3], g_hs[3], g_hbp[3];
    int g_va[3], g_vfp[3], g_vs[3], g_vbp[3];
    int g_hpol[3], g_vpol[3];

    vga_timing_gen u_def (
        .clk(clk), .rst(rst[0]), .ce(ce[0]),
        .h_sync(o_hs[0]), .v_sync(o_vs[0]), .active(o_act[0]),
        .x(o_x[0]), .y(o_y[0]), .line_start(o_ls[0]), .frame_start(o_fs[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1)
    ) u_tiny (
        .clk(clk), .rst(rst[1]), .ce(ce[1]),
        .h_sync(o_hs[1]), .v_sync(o_vs[1]), .active(o_act[1]),
        .x(o_x[1]), .y(o_y[1]), .line_start(o_ls[1]), .frame_start(o_fs[1])
    );

    vga_timing_gen #(
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_SYNC_POL(0), .V_SYNC_POL(1)
    ) u_pf (
        .clk(clk), .rst(rst[2]), .ce(ce[2]),
        .h_sync(o_hs[2]), .v_sync(o_vs[2]), .active(o_act[2]),
        .x(o_x[2]), .y(o_y[2]), .line_start(o_ls[2]), .frame_start(o_fs[2])
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: a linear pixel index within the frame, advanced once per accepted ce.
    int m_pos[3];
    bit m_run[3];
    bit m_ls[3];
    bit m_fs[3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int ht, vt;
            ht = g_ha[i] + g_hfp[i] + g_hs[i] + g_hbp[i];
            vt = g_va[i] + g_vfp[i] + g_vs[i] + g_vbp[i];
            if (rst[i]) begin
                m_run[i] = 1'b0;
                m_pos[i] = 0;
                m_ls[i]  = 1'b0;
                m_fs[i]  = 1'b0;
            end else if (ce[i]) begin
                if (!m_run[i]) begin
                    m_run[i] = 1'b1;
                    m_pos[i] = 0;
                end else begin
                    m_pos[i] = (m_pos[i] + 1) % (ht * vt);
                end
                m_ls[i] = (m_pos[i] % ht) == 0;
                m_fs[i] = (m_pos[i] == 0);
            end else begin
                m_ls[i] = 1'b0;
                m_fs[i] = 1'b0;
            end
        end
    end

    int  p_nce_l[3], p_nce_f[3], p_nact[3];
    bit  p_ok_l[3], p_ok_f[3];

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            int ht, vt, ex, ey, hlo, vlo;
            bit hon, von, eact;
            ht   = g_ha[i] + g_hfp[i] + g_hs[i] + g_hbp[i];
            vt   = g_va[i] + g_vfp[i] + g_vs[i] + g_vbp[i];
            ex   = m_pos[i] % ht;
            ey   = m_pos[i] / ht;
            hlo  = g_ha[i] + g_hfp[i];
            vlo  = g_va[i] + g_vfp[i];
            eact = m_run[i] && ex < g_ha[i] && ey < g_va[i];
            hon  = m_run[i] && ex >= hlo && ex < hlo + g_hs[i];
            von  = m_run[i] && ey >= vlo && ey < vlo + g_vs[i];
            check($sformatf("u%0d_x", i), int'(o_x[i]), ex);
            check($sformatf("u%0d_y", i), int'(o_y[i]), ey);
            check($sformatf("u%0d_active", i), int'(o_act[i]), int'(eact));
            check($sformatf("u%0d_h_sync", i), int'(o_hs[i]), hon ? g_hpol[i] : 1 - g_hpol[i]);
            check($sformatf("u%0d_v_sync", i), int'(o_vs[i]), von ? g_vpol[i] : 1 - g_vpol[i]);
            check($sformatf("u%0d_line_start", i), int'(o_ls[i]), int'(m_ls[i]));
            check($sformatf("u%0d_frame_start", i), int'(o_fs[i]), int'(m_fs[i]));

            // Strobe spacing and visible-pixel count, measured in accepted ce edges.
            if (rst[i]) begin
                p_ok_l[i] = 0; p_ok_f[i] = 0;
                p_nce_l[i] = 0; p_nce_f[i] = 0; p_nact[i] = 0;
            end else if (ce[i]) begin
                p_nce_l[i]++;
                p_nce_f[i]++;
                if (o_ls[i]) begin
                    if (p_ok_l[i]) check($sformatf("u%0d_line_period", i), p_nce_l[i], ht);
                    p_ok_l[i] = 1; p_nce_l[i] = 0;
                end
                if (o_fs[i]) begin
                    if (p_ok_f[i]) begin
                        check($sformatf("u%0d_frame_period", i), p_nce_f[i], ht * vt);
                        check($sformatf("u%0d_active_count", i), p_nact[i], g_ha[i] * g_va[i]);
                    end
                    p_ok_f[i] = 1; p_nce_f[i] = 0; p_nact[i] = 0;
                end
                if (o_act[i]) p_nact[i]++;
            end
        end
        if (n_fail >= 100) begin
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    endtask

    initial begin
        int last_fs, cyc, px, py;
        bit found, pce;

        g_ha = '{640, 4, 640};  g_hfp = '{16, 1, 16}; g_hs = '{96, 2, 96}; g_hbp = '{48, 1, 48};
        g_va = '{480, 3, 20};   g_vfp = '{10, 1, 2};  g_vs = '{2, 1, 2};   g_vbp = '{33, 1, 3};
        g_hpol = '{0, 1, 0};    g_vpol = '{0, 1, 1};
        rst = 3'b111;
        ce  = 3'b111;

        repeat (3) tick();
        check("reset_pf_h_sync", int'(o_hs[2]), 1);
        check("reset_pf_v_sync", int'(o_vs[2]), 0);
        check("reset_tiny_h_sync", int'(o_hs[1]), 0);
        check("reset_def_v_sync", int'(o_vs[0]), 1);

        rst = 3'b000;
        tick();
        check("first_ce_fs", int'(o_fs[0]), 1);
        check("first_ce_ls", int'(o_ls[1]), 1);
        check("first_ce_active", int'(o_act[2]), 1);

        repeat (26000) tick();

        found = 0;
        for (int k = 0; k < 1000 && !found; k++) begin
            if (o_x[0] == 11'd300) found = 1;
            else tick();
        end
        check("find_x300", int'(found), 1);
        rst[0] = 1'b1;
        tick();
        check("midline_rst_x", int'(o_x[0]), 0);
        check("midline_rst_y", int'(o_y[0]), 0);
        check("midline_rst_active", int'(o_act[0]), 0);
        rst[0] = 1'b0;
        tick();
        check("restart_ls", int'(o_ls[0]), 1);
        check("restart_fs", int'(o_fs[0]), 1);

        // Tiny geometry with ce alternating: frame spacing doubles to 96 clocks.
        last_fs = -1;
        cyc = 0;
        for (int k = 0; k < 400; k++) begin
            px  = int'(o_x[1]);
            py  = int'(o_y[1]);
            ce[1] = ~ce[1];
            pce = ce[1];
            tick();
            cyc++;
            if (pce && px == 7 && py == 5) begin
                check("wrap_x", int'(o_x[1]), 0);
                check("wrap_y", int'(o_y[1]), 0);
                check("wrap_fs", int'(o_fs[1]), 1);
                check("wrap_active", int'(o_act[1]), 1);
            end
            if (o_fs[1]) begin
                if (last_fs >= 0) check("toggle_fs_clks", cyc - last_fs, 96);
                last_fs = cyc;
            end
        end

        for (int k = 0; k < 30000; k++) begin
            for (int i = 0; i < 3; i++) begin
                ce[i]  = ($urandom_range(0, 3) != 0);
                rst[i] = ($urandom_range(0, 999) == 0);
            end
            tick();
        end

        rst = 3'b000;
        ce  = 3'b111;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
